// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: SPI mode-0 transaction sequencer for a 64-bit MSB-first
// parallel-load shifter. It accepts a word and a bit count over a
// start/ready handshake, loads the downstream shifter and frames the
// transfer with cs_n and sclk. It pulses the shifter enable once per bit
// boundary and forwards the shifter's serial output to mosi.
// Build option: define SPI_RX_CAPTURE_EN to capture miso into rx_data.
// Without it, miso is ignored and rx_data stays 0.

module spi_frame_ctrl #(
    parameter int DIV = 4               // sclk half-period in clk cycles, 1..255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [63:0] i_tx_data,
    input  logic [6:0]  i_nbits,
    output logic        o_ready,
    output logic        o_load,
    output logic [63:0] o_load_data,
    output logic        o_shift_en,
    input  logic        i_sdo_in,
    output logic        o_sclk,
    output logic        o_cs_n,
    output logic        o_mosi,
    input  logic        i_miso,
    output logic [63:0] o_rx_data,
    output logic        o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_timer;
    logic [6:0]  r_bits;
    logic [63:0] r_load_data;
    logic        r_done;

    logic [6:0]  w_nbits_eff;
    logic        w_phase_last;
    logic        w_last_bit;
    logic        w_accept;
    logic        w_sample;
    logic        w_finish;
    logic        w_load;
    logic        w_shift_en;

    // A count of 0 or anything above 64 means a full 64-bit frame.
    assign w_nbits_eff  = (i_nbits == 7'd0 || i_nbits > 7'd64) ? 7'd64 : i_nbits;
    assign w_phase_last = (r_timer == 8'(DIV - 1));
    assign w_last_bit   = (r_bits == 7'd1);

    // Next-state decode and one-cycle strobes.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        w_next     = r_state;
        w_accept   = 1'b0;
        w_load     = 1'b0;
        w_sample   = 1'b0;
        w_shift_en = 1'b0;
        w_finish   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept = 1'b1;
                    w_next   = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load = 1'b1;
                w_next = S_SETUP;
            end
            S_SETUP: begin
                if (w_phase_last) w_next = S_HIGH;
            end
            S_HIGH: begin
                if (w_phase_last) begin
                    w_sample = 1'b1;
                    if (w_last_bit) begin
                        w_next = S_HOLD;
                    end else begin
                        // The final bit is never shifted past, so the shifter keeps it on mosi.
                        w_shift_en = 1'b1;
                        w_next     = S_LOW;
                    end
                end
            end
            S_LOW: begin
                if (w_phase_last) w_next = S_HIGH;
            end
            S_HOLD: begin
                if (w_phase_last) begin
                    w_finish = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register; reset aborts any frame in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Phase timer: runs 0..DIV-1 in each timed phase, parked at 0 otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                          r_timer <= 8'd0;
        else if (r_state == S_IDLE || r_state == S_LOAD || w_phase_last) r_timer <= 8'd0;
        else                                                   r_timer <= r_timer + 8'd1;
    end

    // Bit counter, word capture and end-of-frame pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bits      <= 7'd0;
            r_load_data <= 64'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_bits      <= w_nbits_eff;
                r_load_data <= i_tx_data;
            end else if (w_sample && !w_last_bit) begin
                r_bits <= r_bits - 7'd1;
            end
        end
    end

`ifdef SPI_RX_CAPTURE_EN
    logic [63:0] r_rx_shift;
    logic [63:0] r_rx_data;

    // Receive path: clear on load, shift miso in at the end of each sclk-high phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_shift <= 64'd0;
            r_rx_data  <= 64'd0;
        end else begin
            if (w_load)        r_rx_shift <= 64'd0;
            else if (w_sample) r_rx_shift <= {r_rx_shift[62:0], i_miso};
            if (w_finish)      r_rx_data  <= r_rx_shift;
        end
    end

    assign o_rx_data = r_rx_data;
`else
    logic w_unused_miso;
    assign w_unused_miso = i_miso;
    assign o_rx_data     = 64'd0;
`endif

    assign o_ready     = (r_state == S_IDLE);
    assign o_cs_n      = (r_state == S_IDLE);
    assign o_sclk      = (r_state == S_HIGH);
    assign o_load      = w_load;
    assign o_shift_en  = w_shift_en;
    assign o_load_data = r_load_data;
    assign o_done      = r_done;
    assign o_mosi      = ~o_cs_n & i_sdo_in;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl: directed bench for spi_frame_ctrl. Three instances run
// with DIV = 1, 2 and 4, each driving a small model of the downstream
// 64-bit MSB-first shifter. Received-data expectations follow the
// SPI_RX_CAPTURE_EN build option.

module tb_spi_frame_ctrl;

    logic        clk;
    logic        rst_n;

    logic        start_w     [3];
    logic [63:0] tx_data_w   [3];
    logic [6:0]  nbits_w     [3];
    logic        ready_w     [3];
    logic        load_w      [3];
    logic [63:0] load_data_w [3];
    logic        shift_w     [3];
    logic        sdo_w       [3];
    logic        sclk_w      [3];
    logic        cs_n_w      [3];
    logic        mosi_w      [3];
    logic        miso_w      [3];
    logic [63:0] rx_data_w   [3];
    logic        done_w      [3];
    logic        lb          [3];   // 1: miso looped back from mosi
    logic        mv          [3];   // constant miso value when not looped back

    int n_vec = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        logic [63:0] sh;

        spi_frame_ctrl #(.DIV(D)) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_start     (start_w[g]),
            .i_tx_data   (tx_data_w[g]),
            .i_nbits     (nbits_w[g]),
            .o_ready     (ready_w[g]),
            .o_load      (load_w[g]),
            .o_load_data (load_data_w[g]),
            .o_shift_en  (shift_w[g]),
            .i_sdo_in    (sdo_w[g]),
            .o_sclk      (sclk_w[g]),
            .o_cs_n      (cs_n_w[g]),
            .o_mosi      (mosi_w[g]),
            .i_miso      (miso_w[g]),
            .o_rx_data   (rx_data_w[g]),
            .o_done      (done_w[g])
        );

        // Downstream parallel-load shifter model.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n)          sh <= 64'd0;
            else if (load_w[g])  sh <= load_data_w[g];
            else if (shift_w[g]) sh <= {sh[62:0], 1'b0};
        end

        assign sdo_w[g]  = sh[63];
        assign miso_w[g] = lb[g] ? mosi_w[g] : mv[g];
    end

    function automatic logic [63:0] exp_rx(input logic [63:0] captured);
`ifdef SPI_RX_CAPTURE_EN
        return captured;
`else
        return 64'd0;
`endif
    endfunction

    // Starts one frame on instance k and observes it until done (bounded).
    // Returns with the caller sitting at the negedge of the done cycle.
    task automatic run_frame(input int k, input logic [63:0] data, input logic [6:0] nb,
                             output int lat, output int rises, output int shifts,
                             output int cs_low, output logic [63:0] bits);
        logic prev_sclk;
        @(negedge clk);
        tx_data_w[k] = data;
        nbits_w[k]   = nb;
        start_w[k]   = 1'b1;
        @(negedge clk);
        start_w[k]   = 1'b0;
        tx_data_w[k] = ~data;
        lat = -1; rises = 0; shifts = 0; cs_low = 0; bits = 64'd0; prev_sclk = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (done_w[k]) begin
                lat = c;
                break;
            end
            if (sclk_w[k] && !prev_sclk) begin
                rises++;
                bits = {bits[62:0], mosi_w[k]};
            end
            prev_sclk = sclk_w[k];
            if (shift_w[k]) shifts++;
            if (!cs_n_w[k]) cs_low++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (ready_w[k] !== 1'b1) begin n_bad++; $display("FAIL reset_ready[%0d] got %b want 1", k, ready_w[k]); end
            n_vec++; if (cs_n_w[k] !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n[%0d] got %b want 1", k, cs_n_w[k]); end
            n_vec++; if ({sclk_w[k], load_w[k], shift_w[k], done_w[k], mosi_w[k]} !== 5'b0) begin
                n_bad++; $display("FAIL reset_strobes[%0d] got %b want 00000", k,
                                  {sclk_w[k], load_w[k], shift_w[k], done_w[k], mosi_w[k]});
            end
            n_vec++; if (load_data_w[k] !== 64'd0) begin n_bad++; $display("FAIL reset_load_data[%0d] got %h want 0", k, load_data_w[k]); end
            n_vec++; if (rx_data_w[k] !== 64'd0) begin n_bad++; $display("FAIL reset_rx_data[%0d] got %h want 0", k, rx_data_w[k]); end
        end
    endtask

    task automatic test_div1_byte();
        int lat, rises, shifts, cs_low;
        logic [63:0] bits;
        lb[0] = 1'b1;
        run_frame(0, 64'hA53C_0F0F_1234_5678, 7'd8, lat, rises, shifts, cs_low, bits);
        n_vec++; if (lat !== 18) begin n_bad++; $display("FAIL byte_latency got %0d want 18", lat); end
        n_vec++; if (rises !== 8) begin n_bad++; $display("FAIL byte_sclk_pulses got %0d want 8", rises); end
        n_vec++; if (bits[7:0] !== 8'hA5) begin n_bad++; $display("FAIL byte_mosi_bits got %h want a5", bits[7:0]); end
        n_vec++; if (shifts !== 7) begin n_bad++; $display("FAIL byte_shift_en got %0d want 7", shifts); end
        n_vec++; if (cs_low !== 18) begin n_bad++; $display("FAIL byte_cs_low got %0d want 18", cs_low); end
        n_vec++; if (load_data_w[0] !== 64'hA53C_0F0F_1234_5678) begin n_bad++; $display("FAIL byte_load_data got %h want a53c0f0f12345678", load_data_w[0]); end
        n_vec++; if (rx_data_w[0] !== exp_rx(64'hA5)) begin n_bad++; $display("FAIL byte_rx got %h want %h", rx_data_w[0], exp_rx(64'hA5)); end
        n_vec++; if ({ready_w[0], cs_n_w[0]} !== 2'b11) begin n_bad++; $display("FAIL byte_done_cycle ready/cs_n got %b want 11", {ready_w[0], cs_n_w[0]}); end
        @(negedge clk);
        n_vec++; if (done_w[0] !== 1'b0) begin n_bad++; $display("FAIL byte_done_width got %b want 0", done_w[0]); end
    endtask

    task automatic test_full_word();
        int lat, rises, shifts, cs_low;
        logic [63:0] bits;
        lb[2] = 1'b1;
        run_frame(2, 64'h0123_4567_89AB_CDEF, 7'd0, lat, rises, shifts, cs_low, bits);
        n_vec++; if (lat !== 517) begin n_bad++; $display("FAIL word_latency got %0d want 517", lat); end
        n_vec++; if (rises !== 64) begin n_bad++; $display("FAIL word_sclk_pulses got %0d want 64", rises); end
        n_vec++; if (shifts !== 63) begin n_bad++; $display("FAIL word_shift_en got %0d want 63", shifts); end
        n_vec++; if (bits !== 64'h0123_4567_89AB_CDEF) begin n_bad++; $display("FAIL word_mosi_bits got %h want 0123456789abcdef", bits); end
        n_vec++; if (rx_data_w[2] !== exp_rx(64'h0123_4567_89AB_CDEF)) begin
            n_bad++; $display("FAIL word_rx got %h want %h", rx_data_w[2], exp_rx(64'h0123_4567_89AB_CDEF));
        end
    endtask

    task automatic test_single_bit();
        int lat, rises, shifts, cs_low;
        logic [63:0] bits;
        lb[1] = 1'b1;
        run_frame(1, 64'h8000_0000_0000_0000, 7'd1, lat, rises, shifts, cs_low, bits);
        n_vec++; if (lat !== 7) begin n_bad++; $display("FAIL bit1_latency got %0d want 7", lat); end
        n_vec++; if (rises !== 1) begin n_bad++; $display("FAIL bit1_sclk_pulses got %0d want 1", rises); end
        n_vec++; if (shifts !== 0) begin n_bad++; $display("FAIL bit1_shift_en got %0d want 0", shifts); end
        n_vec++; if (cs_low !== 7) begin n_bad++; $display("FAIL bit1_cs_low got %0d want 7", cs_low); end
        n_vec++; if (bits[0] !== 1'b1) begin n_bad++; $display("FAIL bit1_mosi got %b want 1", bits[0]); end
        n_vec++; if (rx_data_w[1] !== exp_rx(64'h1)) begin n_bad++; $display("FAIL bit1_rx got %h want %h", rx_data_w[1], exp_rx(64'h1)); end
    endtask

    task automatic test_oversize_nbits();
        int lat, rises, shifts, cs_low;
        logic [63:0] bits;
        lb[0] = 1'b1;
        run_frame(0, 64'h8000_0000_0000_0001, 7'd65, lat, rises, shifts, cs_low, bits);
        n_vec++; if (lat !== 130) begin n_bad++; $display("FAIL n65_latency got %0d want 130", lat); end
        n_vec++; if (rises !== 64) begin n_bad++; $display("FAIL n65_sclk_pulses got %0d want 64", rises); end
        n_vec++; if (bits !== 64'h8000_0000_0000_0001) begin n_bad++; $display("FAIL n65_mosi_bits got %h want 8000000000000001", bits); end
    endtask

    task automatic test_back_to_back();
        int loads, cs_high, d1, d2;
        loads = 0; cs_high = 0; d1 = -1; d2 = -1;
        @(negedge clk);
        tx_data_w[0] = 64'hC000_0000_0000_0000;
        nbits_w[0]   = 7'd4;
        start_w[0]   = 1'b1;
        @(negedge clk);
        // DIV=1, nbits=4: 10 cycles per frame plus the done/idle cycle.
        for (int c = 0; c < 32; c++) begin
            if (load_w[0]) loads++;
            if (cs_n_w[0]) cs_high++;
            if (done_w[0]) begin
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            @(negedge clk);
        end
        start_w[0] = 1'b0;
        n_vec++; if (d1 !== 10) begin n_bad++; $display("FAIL b2b_first_done got %0d want 10", d1); end
        n_vec++; if (d2 !== 21) begin n_bad++; $display("FAIL b2b_second_done got %0d want 21", d2); end
        n_vec++; if (cs_high !== 2) begin n_bad++; $display("FAIL b2b_cs_high_cycles got %0d want 2", cs_high); end
        n_vec++; if (loads !== 3) begin n_bad++; $display("FAIL b2b_load_pulses got %0d want 3", loads); end
        for (int c = 0; c < 40 && !ready_w[0]; c++) @(negedge clk);
        n_vec++; if (ready_w[0] !== 1'b1) begin n_bad++; $display("FAIL b2b_return_idle got %b want 1", ready_w[0]); end
    endtask

    task automatic test_rx_const();
        int lat, rises, shifts, cs_low;
        logic [63:0] bits;
        lb[1] = 1'b0;
        mv[1] = 1'b1;
        run_frame(1, 64'h1234_0000_0000_0000, 7'd16, lat, rises, shifts, cs_low, bits);
        n_vec++; if (lat !== 67) begin n_bad++; $display("FAIL rxc_latency got %0d want 67", lat); end
        n_vec++; if (bits[15:0] !== 16'h1234) begin n_bad++; $display("FAIL rxc_mosi_bits got %h want 1234", bits[15:0]); end
        n_vec++; if (rx_data_w[1] !== exp_rx(64'hFFFF)) begin n_bad++; $display("FAIL rxc_rx got %h want %h", rx_data_w[1], exp_rx(64'hFFFF)); end
        mv[1] = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int lat, rises, shifts, cs_low, dones;
        logic [63:0] bits;
        logic prev_sclk;
        lb[2] = 1'b1;
        @(negedge clk);
        tx_data_w[2] = 64'hBEEF_0000_0000_0000;
        nbits_w[2]   = 7'd16;
        start_w[2]   = 1'b1;
        @(negedge clk);
        start_w[2] = 1'b0;
        rises = 0; prev_sclk = 1'b0;
        for (int c = 0; c < 200 && rises < 5; c++) begin
            if (sclk_w[2] && !prev_sclk) rises++;
            prev_sclk = sclk_w[2];
            if (rises < 5) @(negedge clk);
        end
        n_vec++; if (rises !== 5) begin n_bad++; $display("FAIL mid_reach_bit5 got %0d want 5", rises); end
        rst_n = 1'b0;
        #1;
        n_vec++; if ({cs_n_w[2], sclk_w[2], ready_w[2]} !== 3'b101) begin
            n_bad++; $display("FAIL mid_async_reset cs_n/sclk/ready got %b want 101", {cs_n_w[2], sclk_w[2], ready_w[2]});
        end
        n_vec++; if (load_data_w[2] !== 64'd0) begin n_bad++; $display("FAIL mid_reset_load_data got %h want 0", load_data_w[2]); end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 150; c++) begin
            if (done_w[2]) dones++;
            @(negedge clk);
        end
        n_vec++; if (dones !== 0) begin n_bad++; $display("FAIL mid_no_done got %0d want 0", dones); end
        run_frame(2, 64'hBEEF_0000_0000_0000, 7'd16, lat, rises, shifts, cs_low, bits);
        n_vec++; if (lat !== 133) begin n_bad++; $display("FAIL mid_rerun_latency got %0d want 133", lat); end
        n_vec++; if (bits[15:0] !== 16'hBEEF) begin n_bad++; $display("FAIL mid_rerun_mosi got %h want beef", bits[15:0]); end
        n_vec++; if (shifts !== 15) begin n_bad++; $display("FAIL mid_rerun_shift_en got %0d want 15", shifts); end
        n_vec++; if (rx_data_w[2] !== exp_rx(64'hBEEF)) begin n_bad++; $display("FAIL mid_rerun_rx got %h want %h", rx_data_w[2], exp_rx(64'hBEEF)); end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_w[k]   = 1'b0;
            tx_data_w[k] = 64'd0;
            nbits_w[k]   = 7'd0;
            lb[k]        = 1'b0;
            mv[k]        = 1'b0;
        end
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_div1_byte();
        test_full_word();
        test_single_bit();
        test_oversize_nbits();
        test_back_to_back();
        test_rx_const();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
